// File: rtl/message_stream_arbiter_pkg.sv
// rtl/message_stream_arbiter_pkg.sv - shared header-format helpers and arbiter state encoding (message_pkg)
package message_pkg;

    // Widest data word the helper functions accept
    localparam int MAX_WORD_WIDTH = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_e;

    // Header words carry a 1 in their most significant bit
    function automatic int unsigned hdr_bit(input int unsigned width);
        return width - 1;
    endfunction

    // Channel tag field sits directly below the header flag
    function automatic int unsigned tag_msb(input int unsigned width);
        return width - 2;
    endfunction

    // Payload length lives in the low len_width bits of a header word
    function automatic int unsigned msg_length(input logic [MAX_WORD_WIDTH-1:0] word,
                                               input int unsigned len_width);
        logic [MAX_WORD_WIDTH-1:0] mask;
        mask = (MAX_WORD_WIDTH'(1) << len_width) - MAX_WORD_WIDTH'(1);
        return 32'(word & mask);
    endfunction

endpackage

// File: rtl/message_stream_arbiter_if.sv
// rtl/message_stream_arbiter_if.sv - input channel and output stream bundle of the arbiter
interface message_stream_arbiter_if #(
    parameter int N_STREAMS = 4,
    parameter int WIDTH     = 32
);
    logic [N_STREAMS*WIDTH-1:0] in_data;
    logic [N_STREAMS-1:0]       in_nd;
    logic [WIDTH-1:0]           out_data;
    logic                       out_nd;
    logic [N_STREAMS-1:0]       error;
    logic                       any_error;

    modport master (
        output in_data, in_nd,
        input  out_data, out_nd, error, any_error
    );

    modport slave (
        input  in_data, in_nd,
        output out_data, out_nd, error, any_error
    );
endinterface

// File: rtl/message_stream_arbiter_channel_buffer.sv
// rtl/message_stream_arbiter_channel_buffer.sv - per-channel FIFO with header parsing, rollback and packet count
module message_channel_buffer
    import message_pkg::*;
#(
    parameter int WIDTH             = 32,
    parameter int BUFFER_LENGTH     = 64,
    parameter int LOG_BUFFER_LENGTH = 6,
    parameter int MAX_PACKET_LENGTH = 16,
    parameter int MSG_LENGTH_WIDTH  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_nd_i,
    input  logic             pop_i,
    input  logic             pkt_done_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             pkt_avail_o,
    output logic             error_o
);
    localparam int PW      = LOG_BUFFER_LENGTH + 1;
    localparam int HDR_BIT = hdr_bit(WIDTH);

    logic [WIDTH-1:0]            mem_q [BUFFER_LENGTH];
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]               start_q, start_d;
    logic [PW-1:0]               count_q, count_d;
    logic                        expect_hdr_q, expect_hdr_d;
    logic                        dropping_q, dropping_d;
    logic [MSG_LENGTH_WIDTH-1:0] remain_q, remain_d;
    logic                        error_q, error_d;

    logic                        push, pkt_inc, err_set;
    logic                        full, last_word, len_too_long;
    logic [PW-1:0]               used;
    int unsigned                 in_len;
    logic [MSG_LENGTH_WIDTH-1:0] in_len_w;

    assign used         = wr_ptr_q - rd_ptr_q;
    assign full         = (used == PW'(BUFFER_LENGTH));
    assign in_len       = msg_length(MAX_WORD_WIDTH'(in_data_i), MSG_LENGTH_WIDTH);
    assign in_len_w     = MSG_LENGTH_WIDTH'(in_len);
    assign len_too_long = (in_len > unsigned'(MAX_PACKET_LENGTH));
    assign last_word    = (remain_q == MSG_LENGTH_WIDTH'(1));

    assign rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_i};
    assign count_d  = count_q + {{(PW-1){1'b0}}, pkt_inc} - {{(PW-1){1'b0}}, pkt_done_i};
    assign error_d  = error_q | err_set;

    assign rd_data_o   = mem_q[rd_ptr_q[LOG_BUFFER_LENGTH-1:0]];
    assign pkt_avail_o = (count_q != '0);
    assign error_o     = error_q;

    // Header parse and push decision; an overflow rolls the write pointer back to the packet start
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        start_d      = start_q;
        expect_hdr_d = expect_hdr_q;
        dropping_d   = dropping_q;
        remain_d     = remain_q;
        push         = 1'b0;
        pkt_inc      = 1'b0;
        err_set      = 1'b0;
        if (in_nd_i) begin
            if (expect_hdr_q) begin
                if (!in_data_i[HDR_BIT] || len_too_long) begin
                    err_set = 1'b1;
                end else if (full) begin
                    err_set = 1'b1;
                    if (in_len_w != '0) begin
                        expect_hdr_d = 1'b0;
                        dropping_d   = 1'b1;
                        remain_d     = in_len_w;
                    end
                end else begin
                    push     = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (in_len_w == '0) begin
                        pkt_inc = 1'b1;
                        start_d = wr_ptr_q + PW'(1);
                    end else begin
                        expect_hdr_d = 1'b0;
                        remain_d     = in_len_w;
                    end
                end
            end else begin
                remain_d = remain_q - MSG_LENGTH_WIDTH'(1);
                if (last_word) begin
                    expect_hdr_d = 1'b1;
                    dropping_d   = 1'b0;
                end
                if (!dropping_q) begin
                    if (full) begin
                        err_set  = 1'b1;
                        wr_ptr_d = start_q;
                        if (!last_word) begin
                            dropping_d = 1'b1;
                        end
                    end else begin
                        push     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (last_word) begin
                            pkt_inc = 1'b1;
                            start_d = wr_ptr_q + PW'(1);
                        end
                    end
                end
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            start_q      <= '0;
            count_q      <= '0;
            expect_hdr_q <= 1'b1;
            dropping_q   <= 1'b0;
            remain_q     <= '0;
            error_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            start_q      <= start_d;
            count_q      <= count_d;
            expect_hdr_q <= expect_hdr_d;
            dropping_q   <= dropping_d;
            remain_q     <= remain_d;
            error_q      <= error_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[LOG_BUFFER_LENGTH-1:0]] <= in_data_i;
        end
    end

endmodule

// File: rtl/message_stream_arbiter.sv
// rtl/message_stream_arbiter.sv - round-robin packet arbiter over N channel buffers; optional COMBINER_CHANNEL_TAG_EN
module message_stream_arbiter
    import message_pkg::*;
#(
    parameter int N_STREAMS         = 4,
    parameter int LOG_N_STREAMS     = 2,
    parameter int WIDTH             = 32,
    parameter int BUFFER_LENGTH     = 64,
    parameter int LOG_BUFFER_LENGTH = 6,
    parameter int MAX_PACKET_LENGTH = 16,
    parameter int MSG_LENGTH_WIDTH  = 5
) (
    input logic                     clk,
    input logic                     reset,
    message_stream_arbiter_if.slave bus
);
    if (WIDTH > MAX_WORD_WIDTH) begin : g_width_check
        $error("WIDTH exceeds MAX_WORD_WIDTH");
    end

`ifdef COMBINER_CHANNEL_TAG_EN
    localparam int TAG_MSB = tag_msb(WIDTH);
    if (MSG_LENGTH_WIDTH + LOG_N_STREAMS + 1 > WIDTH) begin : g_tag_check
        $error("channel tag does not fit between header flag and length field");
    end
`endif

    logic [WIDTH-1:0]            rd_data [N_STREAMS];
    logic [N_STREAMS-1:0]        pkt_avail, pop, done, err;

    arb_state_e                  state_q, state_d;
    logic [LOG_N_STREAMS-1:0]    ptr_q, ptr_d;
    logic [LOG_N_STREAMS-1:0]    sel_q, sel_d;
    logic [MSG_LENGTH_WIDTH-1:0] left_q, left_d;
    logic                        hdr_q, hdr_d;
    logic [WIDTH-1:0]            out_data_q, out_data_d;
    logic                        out_nd_q, out_nd_d;

    logic [LOG_N_STREAMS:0]      pick;
    logic [WIDTH-1:0]            cur_word, out_word;
    logic [MSG_LENGTH_WIDTH-1:0] cur_len;
    logic                        last;

    for (genvar g = 0; g < N_STREAMS; g++) begin : g_chan
        message_channel_buffer #(
            .WIDTH             (WIDTH),
            .BUFFER_LENGTH     (BUFFER_LENGTH),
            .LOG_BUFFER_LENGTH (LOG_BUFFER_LENGTH),
            .MAX_PACKET_LENGTH (MAX_PACKET_LENGTH),
            .MSG_LENGTH_WIDTH  (MSG_LENGTH_WIDTH)
        ) u_buf (
            .clk         (clk),
            .reset       (reset),
            .in_data_i   (bus.in_data[g*WIDTH +: WIDTH]),
            .in_nd_i     (bus.in_nd[g]),
            .pop_i       (pop[g]),
            .pkt_done_i  (done[g]),
            .rd_data_o   (rd_data[g]),
            .pkt_avail_o (pkt_avail[g]),
            .error_o     (err[g])
        );
    end

    // First channel at or after start (wrapping) with a complete packet; MSB flags a hit
    function automatic logic [LOG_N_STREAMS:0] rr_pick(input logic [N_STREAMS-1:0] avail,
                                                       input logic [LOG_N_STREAMS-1:0] start);
        logic [LOG_N_STREAMS:0] result;
        int                     idx;
        result = '0;
        for (int k = N_STREAMS - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N_STREAMS;
            if (avail[idx]) begin
                result = {1'b1, idx[LOG_N_STREAMS-1:0]};
            end
        end
        return result;
    endfunction

    assign pick     = rr_pick(pkt_avail, ptr_q);
    assign cur_word = rd_data[sel_q];
    assign cur_len  = MSG_LENGTH_WIDTH'(msg_length(MAX_WORD_WIDTH'(cur_word), MSG_LENGTH_WIDTH));

    // Output word, with the source channel stamped into header words when tagging is built in
    always_comb begin
        out_word = cur_word;
`ifdef COMBINER_CHANNEL_TAG_EN
        if (hdr_q) begin
            out_word[TAG_MSB -: LOG_N_STREAMS] = sel_q;
        end
`endif
    end

    // Arbiter next state: pick a channel in IDLE, stream header plus payload in SEND
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        left_d     = left_q;
        hdr_d      = hdr_q;
        out_data_d = out_data_q;
        out_nd_d   = 1'b0;
        pop        = '0;
        done       = '0;
        last       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick[LOG_N_STREAMS]) begin
                    sel_d   = pick[LOG_N_STREAMS-1:0];
                    hdr_d   = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                pop[sel_q] = 1'b1;
                out_nd_d   = 1'b1;
                out_data_d = out_word;
                if (hdr_q) begin
                    last   = (cur_len == '0);
                    left_d = cur_len;
                end else begin
                    last   = (left_q == MSG_LENGTH_WIDTH'(1));
                    left_d = left_q - MSG_LENGTH_WIDTH'(1);
                end
                hdr_d = 1'b0;
                if (last) begin
                    done[sel_q] = 1'b1;
                    ptr_d       = (sel_q == LOG_N_STREAMS'(N_STREAMS - 1)) ? '0
                                                                          : sel_q + LOG_N_STREAMS'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            left_q     <= '0;
            hdr_q      <= 1'b0;
            out_data_q <= '0;
            out_nd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            left_q     <= left_d;
            hdr_q      <= hdr_d;
            out_data_q <= out_data_d;
            out_nd_q   <= out_nd_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_nd    = out_nd_q;
    assign bus.error     = err;
    assign bus.any_error = |err;

endmodule

// File: tb/tb_message_stream_arbiter.sv
// tb/tb_message_stream_arbiter.sv - directed self-checking bench for message_stream_arbiter
module tb_message_stream_arbiter;
    import message_pkg::*;

`ifdef COMBINER_CHANNEL_TAG_EN
    localparam bit TAG_ON = 1'b1;
`else
    localparam bit TAG_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    int   last_in;

    logic [31:0] oq_data [$];
    int          oq_cyc  [$];

    message_stream_arbiter_if #(.N_STREAMS(4), .WIDTH(32)) bus ();

    message_stream_arbiter #(
        .N_STREAMS         (4),
        .LOG_N_STREAMS     (2),
        .WIDTH             (32),
        .BUFFER_LENGTH     (8),
        .LOG_BUFFER_LENGTH (3),
        .MAX_PACKET_LENGTH (16),
        .MSG_LENGTH_WIDTH  (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_nd === 1'b1) begin
            oq_data.push_back(bus.out_data);
            oq_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] exp_hdr(input int ch, input logic [31:0] h);
        logic [31:0] r;
        r        = h;
        r[30:29] = TAG_ON ? 2'(ch) : h[30:29];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] nd, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        bus.in_nd   = nd;
        bus.in_data = {d3, d2, d1, d0};
        @(posedge clk);
        #1;
        bus.in_nd   = '0;
        last_in     = cyc;
    endtask

    task automatic send1(input int ch, input logic [31:0] d);
        logic [127:0] dd;
        logic [3:0]   nd;
        dd = '0;
        nd = '0;
        dd[ch*32 +: 32] = d;
        nd[ch]          = 1'b1;
        drive(nd, dd[31:0], dd[63:32], dd[95:64], dd[127:96]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        oq_data.delete();
        oq_cyc.delete();
    endtask

    initial begin
        int waited;
        cyc         = 0;
        checks      = 0;
        failures    = 0;
        last_in     = 0;
        reset       = 1'b1;
        bus.in_nd   = '0;
        bus.in_data = '0;
        #1;
        chk("reset_out_nd", 64'(bus.out_nd), 64'd0);
        chk("reset_out_data", 64'(bus.out_data), 64'd0);
        chk("reset_error", 64'(bus.error), 64'd0);
        chk("reset_any_error", 64'(bus.any_error), 64'd0);
        idle(2);
        reset = 1'b0;
        idle(2);

        // Three channels complete 2-payload packets together; served 0,1,3
        clear_q();
        drive(4'b1011, 32'h80000002, 32'h80000002, 32'h0, 32'h80000002);
        drive(4'b1011, 32'h100, 32'h110, 32'h0, 32'h130);
        drive(4'b1011, 32'h101, 32'h111, 32'h0, 32'h131);
        idle(20);
        chk("rr_count", 64'(oq_data.size()), 64'd9);
        chk("rr_w0", 64'(oq_data[0]), 64'(exp_hdr(0, 32'h80000002)));
        chk("rr_w2", 64'(oq_data[2]), 64'h101);
        chk("rr_w3", 64'(oq_data[3]), 64'(exp_hdr(1, 32'h80000002)));
        chk("rr_w4", 64'(oq_data[4]), 64'h110);
        chk("rr_w6", 64'(oq_data[6]), 64'(exp_hdr(3, 32'h80000002)));
        chk("rr_w8", 64'(oq_data[8]), 64'h131);
        chk("rr_gap1", 64'(oq_cyc[3] - oq_cyc[2]), 64'd2);
        chk("rr_gap2", 64'(oq_cyc[6] - oq_cyc[5]), 64'd2);
        chk("rr_ptr_end", 64'(dut.ptr_q), 64'd0);

        // Single packet on channel 2, latency and contents
        clear_q();
        send1(2, 32'h80000003);
        send1(2, 32'hA);
        send1(2, 32'hB);
        send1(2, 32'hC);
        idle(10);
        chk("ch2_count", 64'(oq_data.size()), 64'd4);
        chk("ch2_hdr", 64'(oq_data[0]), 64'(exp_hdr(2, 32'h80000003)));
        chk("ch2_w1", 64'(oq_data[1]), 64'hA);
        chk("ch2_w2", 64'(oq_data[2]), 64'hB);
        chk("ch2_w3", 64'(oq_data[3]), 64'hC);
        chk("ch2_latency", 64'(oq_cyc[0] - last_in), 64'd2);
        chk("ch2_burst", 64'(oq_cyc[3] - oq_cyc[0]), 64'd3);
        chk("ch2_error", 64'(bus.error), 64'd0);

        // Over-long header on channel 1 is dropped, next packet forwarded
        clear_q();
        send1(1, 32'h80000014);
        idle(6);
        chk("long_error", 64'(bus.error), 64'b0010);
        chk("long_any_error", 64'(bus.any_error), 64'd1);
        chk("long_no_out", 64'(oq_data.size()), 64'd0);
        send1(1, 32'h80000001);
        send1(1, 32'h55);
        idle(6);
        chk("long_next_count", 64'(oq_data.size()), 64'd2);
        chk("long_next_hdr", 64'(oq_data[0]), 64'(exp_hdr(1, 32'h80000001)));
        chk("long_next_pay", 64'(oq_data[1]), 64'h55);

        // Channel 0 overflows its 8-word FIFO while channel 3 is being sent
        clear_q();
        send1(3, 32'h80000005);
        for (int i = 0; i < 5; i++) send1(3, 32'h300 + 32'(i));
        send1(0, 32'h8000000A);
        for (int i = 0; i < 10; i++) send1(0, 32'h200 + 32'(i));
        send1(0, 32'h80000002);
        send1(0, 32'h21);
        send1(0, 32'h22);
        idle(10);
        chk("ovf_error", 64'(bus.error), 64'b0011);
        chk("ovf_count", 64'(oq_data.size()), 64'd9);
        chk("ovf_ch3_hdr", 64'(oq_data[0]), 64'(exp_hdr(3, 32'h80000005)));
        chk("ovf_ch3_last", 64'(oq_data[5]), 64'h304);
        chk("ovf_ch0_hdr", 64'(oq_data[6]), 64'(exp_hdr(0, 32'h80000002)));
        chk("ovf_ch0_w1", 64'(oq_data[7]), 64'h21);
        chk("ovf_ch0_w2", 64'(oq_data[8]), 64'h22);

        // Reset in the middle of a 5-word packet
        clear_q();
        send1(2, 32'h80000004);
        for (int i = 0; i < 4; i++) send1(2, 32'h400 + 32'(i));
        waited = 0;
        while (oq_data.size() < 2 && waited < 30) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("midrst_reached", 64'(oq_data.size()), 64'd2);
        reset = 1'b1;
        #1;
        chk("midrst_out_nd", 64'(bus.out_nd), 64'd0);
        chk("midrst_error", 64'(bus.error), 64'd0);
        chk("midrst_any_error", 64'(bus.any_error), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(15);
        chk("midrst_no_more", 64'(oq_data.size()), 64'd2);

        // Header tag on channel 3 (pass-through when tagging is not built in)
        clear_q();
        send1(3, 32'h80000001);
        send1(3, 32'h77);
        idle(6);
        chk("tag_count", 64'(oq_data.size()), 64'd2);
        chk("tag_hdr", 64'(oq_data[0]), TAG_ON ? 64'hE0000001 : 64'h80000001);
        chk("tag_pay", 64'(oq_data[1]), 64'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
